// File: rtl/dac8531_pkg.sv
// dac8531_pkg: shared types, frame constants and power-down modes for the DAC8531 transmitter
package dac8531_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    localparam int FRAME_BITS = 24;
    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [1:0] mode, input logic [15:0] data);
        return {6'b000000, mode, data};
    endfunction
endpackage

// File: rtl/dac_sclk_gen.sv
// dac_sclk_gen: registered serial clock with half-period counter; strobes the end of each low phase
module dac_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    input  logic stop,
    output logic sclk,
    output logic lo_end
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic          active;
    logic [CW-1:0] cnt;
    logic          last;
    assign last   = cnt == CW'(CLK_DIV - 1);
    assign lo_end = active && !sclk && last;
    // sclk doubles as the phase flag: a frame always opens on a high phase
    always_ff @(posedge clk) begin
        if (!rstn || stop) begin
            active <= 1'b0;
            sclk   <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            active <= 1'b1;
            sclk   <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) sclk <= ~sclk;
        end
    end
endmodule

// File: rtl/dac8531_tx.sv
// dac8531_tx: shifts a 24-bit {mode, code} frame MSB-first to a DAC8531 over SYNC/SCLK/DIN
module dac8531_tx
    import dac8531_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int SYNC_GAP = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        da_start,
    input  logic [15:0] da_data,
    input  logic [1:0]  da_mode,
    output logic        da_busy,
    output logic        da_done,
    output logic        da_syncn,
    output logic        da_sclk,
    output logic        da_din
);
    localparam int GW = SYNC_GAP > 1 ? $clog2(SYNC_GAP) : 1;
    state_t                state, state_n;
    logic [FRAME_BITS-1:0] sr, sr_n;
    logic [4:0]            bit_cnt, bit_n;
    logic [GW-1:0]         gap_cnt, gap_n;
    logic                  load, stop, lo_end;
    dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk    (clk),
        .rstn   (rstn),
        .load   (load),
        .stop   (stop),
        .sclk   (da_sclk),
        .lo_end (lo_end)
    );
    assign da_din = sr[FRAME_BITS-1];
    always_comb begin
        state_n = state;
        sr_n    = sr;
        bit_n   = bit_cnt;
        gap_n   = gap_cnt;
        load    = 1'b0;
        stop    = 1'b0;
        case (state)
            IDLE: if (da_start) begin
                state_n = SHIFT;
                load    = 1'b1;
                sr_n    = make_frame(da_mode, da_data);
                bit_n   = '0;
            end
            SHIFT: if (lo_end) begin
                if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                    state_n = GAP;
                    stop    = 1'b1;
                    sr_n    = '0;
                    gap_n   = '0;
                end else begin
                    sr_n  = {sr[FRAME_BITS-2:0], 1'b0};
                    bit_n = bit_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GW'(SYNC_GAP - 1)) state_n = IDLE;
                else gap_n = gap_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    // status outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            da_syncn <= 1'b1;
            da_busy  <= 1'b0;
            da_done  <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            bit_cnt  <= bit_n;
            gap_cnt  <= gap_n;
            da_syncn <= state_n != SHIFT;
            da_busy  <= state_n != IDLE;
            da_done  <= state_n == GAP && gap_n == GW'(SYNC_GAP - 1);
        end
    end
endmodule

// File: tb/tb_dac8531_tx.sv
// tb_dac8531_tx: directed checks of frame content, timing, busy rejection and reset abort
module tb_dac8531_tx;
    import dac8531_pkg::*;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] da_data = '0;
    logic [1:0]  da_mode = '0;
    logic        busy0, done0, syncn0, sclk0, din0;
    logic        busy1, done1, syncn1, sclk1, din1;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [23:0] bits;
    int          nfall, lowcnt, done_at, idle_at, gapcnt;

    always #5 clk = ~clk;

    dac8531_tx u0 (
        .clk(clk), .rstn(rstn), .da_start(start0), .da_data(da_data), .da_mode(da_mode),
        .da_busy(busy0), .da_done(done0), .da_syncn(syncn0), .da_sclk(sclk0), .da_din(din0)
    );
    dac8531_tx #(.CLK_DIV(1), .SYNC_GAP(1)) u1 (
        .clk(clk), .rstn(rstn), .da_start(start1), .da_data(da_data), .da_mode(da_mode),
        .da_busy(busy1), .da_done(done1), .da_syncn(syncn1), .da_sclk(sclk1), .da_din(din1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_syncn"}, 32'(syncn0), 32'd1);
        check({tag, "_sclk"},  32'(sclk0),  32'd0);
        check({tag, "_din"},   32'(din0),   32'd0);
        check({tag, "_busy"},  32'(busy0),  32'd0);
        check({tag, "_done"},  32'(done0),  32'd0);
    endtask

    // One frame on DUT f; n counts edges after the accepting edge; pokes pulse start while busy.
    task automatic frame(input bit f, input logic [15:0] d, input logic [1:0] m,
                         input int poke1, input int poke2,
                         output logic [23:0] b, output int nf, output int lo,
                         output int dn, output int id, output int gp);
        logic ps, pd, s, c, di, bz, dq;
        b = '0; nf = 0; lo = 0; dn = -1; id = -1; gp = 0;
        da_data = d; da_mode = m;
        if (f) start1 = 1'b1; else start0 = 1'b1;
        tick;
        start0 = 1'b0; start1 = 1'b0;
        ps = 1'b0; pd = 1'b0;
        for (int n = 0; n < 200; n++) begin
            s  = f ? syncn1 : syncn0;
            c  = f ? sclk1  : sclk0;
            di = f ? din1   : din0;
            bz = f ? busy1  : busy0;
            dq = f ? done1  : done0;
            if (!s) lo++;
            if (s && bz) gp++;
            if (ps && !c) begin b = {b[22:0], pd}; nf++; end
            if (dq && dn < 0) dn = n;
            if (!bz) begin id = n; break; end
            ps = c; pd = di;
            if (n == 1) begin da_data = ~d; da_mode = ~m; end
            if (n == poke1 || n == poke2) begin
                if (f) start1 = 1'b1; else start0 = 1'b1;
            end else begin
                start0 = 1'b0; start1 = 1'b0;
            end
            tick;
        end
        start0 = 1'b0; start1 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin
            tick;
            check_idle("reset");
        end
        rstn = 1'b1;
        tick;
        check_idle("idle");

        frame(1'b0, 16'hA5C3, PD_NORMAL, -1, -1, bits, nfall, lowcnt, done_at, idle_at, gapcnt);
        check("a5c3_bits", 32'(bits), 32'h00A5C3);
        check("a5c3_falls", 32'(nfall), 32'd24);
        check("a5c3_synclow", 32'(lowcnt), 32'd96);
        check("a5c3_done", 32'(done_at), 32'd99);
        check("a5c3_idle", 32'(idle_at), 32'd100);

        frame(1'b0, 16'h0000, PD_HIZ, -1, -1, bits, nfall, lowcnt, done_at, idle_at, gapcnt);
        check("pd_bits", 32'(bits), 32'h030000);
        check("pd_falls", 32'(nfall), 32'd24);

        frame(1'b0, 16'h1234, PD_1K, 19, 98, bits, nfall, lowcnt, done_at, idle_at, gapcnt);
        check("busy_bits", 32'(bits), 32'h011234);
        check("busy_idle", 32'(idle_at), 32'd100);
        check("busy_gap", 32'(gapcnt), 32'd4);
        frame(1'b0, 16'h5A0F, PD_100K, -1, -1, bits, nfall, lowcnt, done_at, idle_at, gapcnt);
        check("b2b_bits", 32'(bits), 32'h025A0F);
        check("b2b_done", 32'(done_at), 32'd99);

        da_data = 16'hFFFF; da_mode = PD_HIZ;
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int i = 0; i < 53; i++) tick;
        check("mid_sync", 32'(syncn0), 32'd0);
        rstn = 1'b0;
        tick;
        check_idle("abort");
        tick;
        check("abort_done1", 32'(done0), 32'd0);
        tick;
        check("abort_done2", 32'(done0), 32'd0);
        rstn = 1'b1;
        tick;
        check_idle("abort_rel");
        frame(1'b0, 16'hA5C3, PD_NORMAL, -1, -1, bits, nfall, lowcnt, done_at, idle_at, gapcnt);
        check("after_bits", 32'(bits), 32'h00A5C3);
        check("after_done", 32'(done_at), 32'd99);

        frame(1'b1, 16'hFFFF, PD_NORMAL, -1, -1, bits, nfall, lowcnt, done_at, idle_at, gapcnt);
        check("fast_bits", 32'(bits), 32'h00FFFF);
        check("fast_falls", 32'(nfall), 32'd24);
        check("fast_synclow", 32'(lowcnt), 32'd48);
        check("fast_done", 32'(done_at), 32'd48);
        check("fast_idle", 32'(idle_at), 32'd49);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
